crc_transmitter: RTL and testbench

Upstream partner of the CRC receiver stage. It accepts a BW-bit data word over a valid/ready handshake and computes its CRC_BW-bit remainder serially, one message bit per clock, using an LFSR over DIVISOR. It then presents the codeword {data, crc} through a second valid/ready handshake. The codeword format matches what the receiver checks: data in the MSBs, CRC in the LSBs, and a zero remainder over the full word when error-free.

---
 rtl/crc_transmitter_if.sv | 31 +++
 rtl/crc_transmitter.sv | 113 +++++++++++
 tb/tb_crc_transmitter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/crc_transmitter_if.sv
// Handshake bundle for the CRC transmitter: word-in valid/ready and codeword-out valid/ready.
// The "slave" view belongs to the transmitter, the "master" view to whatever feeds and drains it.
interface crc_transmitter_if #(
    parameter int BW     = 4,
    parameter int CRC_BW = 3
);
    logic [BW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [BW+CRC_BW-1:0] out;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/crc_transmitter.sv
// Serial CRC encoder: accepts a BW-bit word, runs one message bit per clock through an LFSR over
// DIVISOR, then presents the codeword {data, crc} until downstream takes it.
module crc_transmitter #(
    parameter int              BW      = 4,
    parameter int              CRC_BW  = 3,
    parameter logic [CRC_BW:0] DIVISOR = 4'b1011
) (
    input  logic               clk,
    input  logic               rstn,
    crc_transmitter_if.slave   bus
);

    localparam int              CNT_W    = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                 state_r;
    logic [BW-1:0]          data_r;
    logic [BW-1:0]          shift_r;
    logic [CRC_BW-1:0]      rem_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [BW+CRC_BW-1:0]   out_r;
    logic                   out_valid_r;

    logic [CRC_BW-1:0]      rem_next_s;
    logic                   last_bit_s;
    logic                   in_ready_s;

    // One LFSR step: feed a single message bit (MSB-first) into the running remainder.
    function automatic logic [CRC_BW-1:0] crc_step(
        input logic [CRC_BW-1:0] rem,
        input logic              msg_bit
    );
        logic fb;
        fb       = rem[CRC_BW-1] ^ msg_bit;
        crc_step = {rem[CRC_BW-2:0], 1'b0} ^ (fb ? DIVISOR[CRC_BW-1:0] : {CRC_BW{1'b0}});
    endfunction

    // Next remainder, terminal-count and ready decode.
    always_comb begin
        rem_next_s = crc_step(rem_r, shift_r[BW-1]);
        if (cnt_r == CNT_LAST) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;

    // Control FSM with the datapath registers and the registered codeword output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            data_r      <= {BW{1'b0}};
            shift_r     <= {BW{1'b0}};
            rem_r       <= {CRC_BW{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_r       <= {(BW+CRC_BW){1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (bus.in_valid) begin
                        data_r  <= bus.in_data;
                        shift_r <= bus.in_data;
                        rem_r   <= {CRC_BW{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= CALC;
                    end
                end
                CALC: begin
                    rem_r   <= rem_next_s;
                    shift_r <= shift_r << 1;
                    // The final bit lands straight in the output register so DONE needs no extra cycle.
                    if (last_bit_s) begin
                        cnt_r       <= {CNT_W{1'b0}};
                        out_r       <= {data_r, rem_next_s};
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r       <= cnt_r + CNT_W'(1);
                        out_valid_r <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_transmitter.sv
// Directed and randomized bench for crc_transmitter; expected codewords come from
// polynomial long division over GF(2) done on plain integers.
module tb_crc_transmitter;

    localparam int          BW     = 4;
    localparam int          CRC_BW = 3;
    localparam int unsigned DIV    = 32'd11;

    logic clk = 1'b0;
    logic rstn;

    crc_transmitter_if #(.BW(BW), .CRC_BW(CRC_BW)) bus();

    crc_transmitter #(
        .BW(BW),
        .CRC_BW(CRC_BW),
        .DIVISOR(4'b1011)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Remainder of a width-bit polynomial divided by DIV.
    function automatic int unsigned poly_mod(input int unsigned v, input int width);
        for (int i = width - 1; i >= CRC_BW; i--) begin
            if (v[i]) v = v ^ (DIV << (i - CRC_BW));
        end
        return v;
    endfunction

    function automatic int unsigned codeword(input int unsigned d);
        int unsigned shifted;
        shifted = d << CRC_BW;
        return shifted | poly_mod(shifted, BW + CRC_BW);
    endfunction

    // Present a word for one cycle from an idle negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] d);
        check("send_ready", bus.in_ready, 1);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy_after_accept", bus.in_ready, 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", bus.out_valid, 1);
    endtask

    logic [3:0] vecs   [3] = '{4'b0000, 4'b1111, 4'b1000};
    logic [6:0] exp_cw [3] = '{7'b0000000, 7'b1111111, 7'b1000101};

    initial begin
        int lat;
        int dly;
        int idx;
        int seen;
        int last_t;
        int t;
        int extra;
        logic pend;
        logic [3:0] d;

        bus.in_data   = 4'b0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rstn          = 1'b0;
        repeat (3) @(negedge clk);
        bus.in_valid  = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out, 0);
        bus.in_valid  = 1'b0;
        rstn          = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("idle_after_rst", bus.out_valid, 0);

        // First word, latency and handshake return
        send(4'b1101);
        wait_valid(lat);
        check("latency", lat, BW);
        check("word_1101", bus.out, 7'b1101001);
        @(negedge clk);
        check("valid_drop", bus.out_valid, 0);
        check("ready_back", bus.in_ready, 1);

        // Polynomial vectors with receiver-side cross-check
        for (int i = 0; i < 3; i++) begin
            send(vecs[i]);
            wait_valid(lat);
            check("vec_const", bus.out, exp_cw[i]);
            check("vec_model", bus.out, codeword(vecs[i]));
            check("vec_rx_rem", poly_mod(bus.out, BW + CRC_BW), 0);
            check("vec_rx_data", bus.out[6:3], vecs[i]);
            @(negedge clk);
        end

        // Random words with random backpressure
        for (int i = 0; i < 20; i++) begin
            d   = 4'($urandom_range(15));
            dly = $urandom_range(3);
            bus.out_ready = (dly == 0);
            send(d);
            wait_valid(lat);
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                check("rnd_hold_valid", bus.out_valid, 1);
            end
            bus.out_ready = 1'b1;
            check("rnd_word", bus.out, codeword(d));
            check("rnd_rx_rem", poly_mod(bus.out, BW + CRC_BW), 0);
            @(negedge clk);
            check("rnd_done", bus.out_valid, 0);
        end

        // Backpressure with an ignored second request
        bus.out_ready = 1'b0;
        send(4'b1101);
        wait_valid(lat);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = (k == 3);
            bus.in_data  = 4'b0110;
            @(negedge clk);
            check("bp_out", bus.out, 7'b1101001);
            check("bp_valid", bus.out_valid, 1);
            check("bp_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) extra++;
        end
        check("bp_single_transfer", extra, 0);

        // Input changes during CALC are ignored
        send(4'b1011);
        bus.in_data  = 4'b0110;
        bus.in_valid = 1'b1;
        wait_valid(lat);
        bus.in_valid = 1'b0;
        check("busy_ignore", bus.out, codeword(4'b1011));
        @(negedge clk);
        check("busy_idle", bus.in_ready, 1);

        // Asynchronous reset in CALC
        send(4'b1111);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_out", bus.out, 0);
        check("mid_rst_ready", bus.in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send(4'b1000);
        wait_valid(lat);
        check("post_rst_word", bus.out, 7'b1000101);
        @(negedge clk);

        // Asynchronous reset in DONE drops out_valid at once
        bus.out_ready = 1'b0;
        send(4'b1101);
        wait_valid(lat);
        #2 rstn = 1'b0;
        #1;
        check("done_rst_valid", bus.out_valid, 0);
        check("done_rst_out", bus.out, 0);
        check("done_rst_ready", bus.in_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Back-to-back stream 0..15
        idx    = 0;
        seen   = 0;
        last_t = 0;
        t      = 0;
        bus.in_data  = 4'd0;
        bus.in_valid = 1'b1;
        pend = bus.in_ready && bus.in_valid;
        while (seen < 16 && t < 300) begin
            @(negedge clk);
            t++;
            if (bus.out_valid === 1'b1) begin
                check("stream_word", bus.out, codeword(seen));
                if (seen > 0) check("stream_spacing", t - last_t, BW + 2);
                last_t = t;
                seen++;
            end
            if (pend) begin
                idx++;
                if (idx < 16) bus.in_data = idx[3:0];
                else          bus.in_valid = 1'b0;
            end
            pend = bus.in_ready && bus.in_valid;
        end
        bus.in_valid = 1'b0;
        check("stream_count", seen, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
